// File: rtl/bus_arbiter.sv
// Two-master arbiter and transaction sequencer for the 32-bit system bus.
// Define ARB_FIXED_PRIORITY_EN to make master 0 win every tie; by default ties alternate round-robin.
module bus_arbiter #(
  parameter logic [3:0] RAM_WAIT = 4'd1,
  parameter logic [3:0] IO_WAIT  = 4'd2,
  parameter logic [3:0] GFX_WAIT = 4'd0
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        M0_Req_H,
  input  logic        M1_Req_H,
  input  logic        M0_Write_H,
  input  logic        M1_Write_H,
  input  logic [31:0] M0_Address,
  input  logic [31:0] M1_Address,
  input  logic [31:0] M0_WData,
  input  logic [31:0] M1_WData,
  output logic        M0_Ack_H,
  output logic        M1_Ack_H,
  output logic        M0_Err_H,
  output logic        M1_Err_H,
  output logic [31:0] M0_RData,
  output logic [31:0] M1_RData,
  output logic [31:0] Bus_Address,
  output logic [31:0] Bus_WData,
  output logic        Bus_Write_H,
  output logic        Bus_Strobe_H,
  input  logic [31:0] Bus_RData,
  input  logic        RAM_Select_H,
  input  logic        IO_Select_H,
  input  logic        Graphics_Select_H,
  output logic        Grant_M1_H
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_ACK} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_err, w_err_next;
  logic [31:0] r_rdata, w_rdata_next;
  logic        r_grant_m1, w_grant_m1_next;
  logic [31:0] r_bus_addr, r_bus_wdata;
  logic        r_bus_write;

  logic        w_any_req;
  logic        w_win_m1;
  logic        w_start;
  logic        w_mapped;
  logic [3:0]  w_sel_wait;
  logic        w_ack;

  assign w_any_req = M0_Req_H | M1_Req_H;
  assign w_start   = (r_state == S_IDLE) && w_any_req;

`ifdef ARB_FIXED_PRIORITY_EN
  assign w_win_m1 = M1_Req_H & ~M0_Req_H;
`else
  // r_last_m1 remembers the previous winner; reset to M1 so M0 takes the first tie.
  logic r_last_m1;
  assign w_win_m1 = M1_Req_H & (~M0_Req_H | ~r_last_m1);

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_last_m1 <= 1'b1;
    end else if (w_start) begin
      r_last_m1 <= w_win_m1;
    end
  end
`endif

  // Overlapping decoder selects resolve RAM > IO > Graphics.
  assign w_mapped   = RAM_Select_H | IO_Select_H | Graphics_Select_H;
  assign w_sel_wait = RAM_Select_H ? RAM_WAIT :
                      IO_Select_H  ? IO_WAIT  : GFX_WAIT;

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_grant_m1  <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_bus_write <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_err      <= w_err_next;
      r_rdata    <= w_rdata_next;
      r_grant_m1 <= w_grant_m1_next;
      if (w_start) begin
        r_bus_addr  <= w_win_m1 ? M1_Address : M0_Address;
        r_bus_wdata <= w_win_m1 ? M1_WData   : M0_WData;
        r_bus_write <= w_win_m1 ? M1_Write_H : M0_Write_H;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_err_next      = r_err;
    w_rdata_next    = r_rdata;
    w_grant_m1_next = r_grant_m1;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_next    = S_ADDR;
          w_grant_m1_next = w_win_m1;
          w_err_next      = 1'b0;
        end
      end
      S_ADDR: begin
        w_cnt_next = w_sel_wait;
        w_err_next = ~w_mapped;
        if (!w_mapped) begin
          w_state_next = S_ACK;
          w_rdata_next = 32'h0;
        end else if (w_sel_wait == 4'd0) begin
          w_state_next = S_ACK;
          w_rdata_next = r_bus_write ? 32'h0 : Bus_RData;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = S_ACK;
          w_rdata_next = r_bus_write ? 32'h0 : Bus_RData;
        end
      end
      S_ACK: begin
        w_state_next    = S_IDLE;
        w_grant_m1_next = 1'b0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Responses are decoded from state so an asynchronous reset silences them immediately.
  assign w_ack        = (r_state == S_ACK);
  assign Bus_Strobe_H = (r_state == S_ADDR) || (r_state == S_WAIT);
  assign Bus_Address  = r_bus_addr;
  assign Bus_WData    = r_bus_wdata;
  assign Bus_Write_H  = r_bus_write;
  assign Grant_M1_H   = r_grant_m1;
  assign M0_Ack_H     = w_ack & ~r_grant_m1;
  assign M1_Ack_H     = w_ack &  r_grant_m1;
  assign M0_Err_H     = M0_Ack_H & r_err;
  assign M1_Err_H     = M1_Ack_H & r_err;
  assign M0_RData     = M0_Ack_H ? r_rdata : 32'h0;
  assign M1_RData     = M1_Ack_H ? r_rdata : 32'h0;

endmodule
